// File: rtl/pong_pkg.sv
// Shared pong geometry, FSM state encoding and derived serve coordinates.
package pong_pkg;

  localparam int unsigned HScreen  = 640;
  localparam int unsigned VScreen  = 480;
  localparam int unsigned Border   = 10;
  localparam int unsigned BallSize = 10;
  localparam int unsigned POffset  = 20;
  localparam int unsigned PWidth   = 8;
  localparam int unsigned PHigh    = 96;
  localparam int unsigned Speed    = 2;
  localparam int unsigned MaxStep  = 6;

  localparam int unsigned ServeXLeft  = Border + POffset + PWidth;              // 38
  localparam int unsigned ServeXRight = HScreen - ServeXLeft - BallSize;        // 592
  localparam int unsigned ServeY      = (VScreen - BallSize) / 2;               // 235

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StScored
  } state_e;

endpackage

// File: rtl/ball_collide.sv
// Combinational paddle-overlap and edge-proximity flags for the ball FSM.
module ball_collide
  import pong_pkg::*;
#(
  parameter int unsigned H_SCREEN  = HScreen,
  parameter int unsigned V_SCREEN  = VScreen,
  parameter int unsigned BORDER    = Border,
  parameter int unsigned BALL_SIZE = BallSize,
  parameter int unsigned P_OFFSET  = POffset,
  parameter int unsigned P_WIDTH   = PWidth,
  parameter int unsigned P_HIGH    = PHigh,
  parameter int unsigned SPEED     = Speed
) (
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic       dx_right,
  input  logic       dy_down,
  input  logic [2:0] step,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_y,
  output logic       hit_r,
  output logic       hit_l,
  output logic       miss_r,
  output logic       miss_l,
  output logic       bounce_bot,
  output logic       bounce_top
);

  localparam logic [10:0] PadL = 11'(BORDER + P_OFFSET + P_WIDTH);
  localparam logic [10:0] PadR = 11'(H_SCREEN - BORDER - P_OFFSET - P_WIDTH);

  logic [10:0] bx, by, stp, right_edge, bot_edge, p1, p2;
  logic        ov_l, ov_r;

  // 11-bit arithmetic so right_edge + step can never wrap.
  always_comb begin
    bx         = {1'b0, ball_x};
    by         = {1'b0, ball_y};
    stp        = {8'd0, step};
    p1         = {1'b0, p1_y};
    p2         = {1'b0, p2_y};
    right_edge = bx + 11'(BALL_SIZE);
    bot_edge   = by + 11'(BALL_SIZE);
    ov_l       = (bot_edge > p1) && (by < p1 + 11'(P_HIGH));
    ov_r       = (bot_edge > p2) && (by < p2 + 11'(P_HIGH));
    hit_r      = dx_right && (right_edge <= PadR) && (right_edge + stp >= PadR) && ov_r;
    hit_l      = !dx_right && (bx >= PadL) && (bx <= PadL + stp) && ov_l;
    miss_r     = dx_right && (right_edge + stp >= 11'(H_SCREEN - BORDER));
    miss_l     = !dx_right && (bx <= 11'(BORDER) + stp);
    bounce_bot = dy_down && (bot_edge + 11'(SPEED) >= 11'(V_SCREEN - BORDER));
    bounce_top = !dy_down && (by <= 11'(BORDER + SPEED));
  end

endmodule

// File: rtl/ball_engine.sv
// Pong ball motion FSM (IDLE/PLAY/SCORED) with paddle bounce and scoring.
// Define BALL_ENGINE_SPEEDUP_EN to speed the ball up every fourth paddle hit.
module ball_engine
  import pong_pkg::*;
#(
  parameter int unsigned H_SCREEN  = HScreen,
  parameter int unsigned V_SCREEN  = VScreen,
  parameter int unsigned BORDER    = Border,
  parameter int unsigned BALL_SIZE = BallSize,
  parameter int unsigned P_OFFSET  = POffset,
  parameter int unsigned P_WIDTH   = PWidth,
  parameter int unsigned P_HIGH    = PHigh,
  parameter int unsigned SPEED     = Speed
) (
  input  logic       clk_pix,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic       serve_side,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       in_play,
  output logic       paddle_hit,
  output logic       point_p1,
  output logic       point_p2
);

  localparam logic [9:0] XLeft    = 10'(BORDER + P_OFFSET + P_WIDTH);
  localparam logic [9:0] XRight   = 10'(H_SCREEN - (BORDER + P_OFFSET + P_WIDTH) - BALL_SIZE);
  localparam logic [9:0] YServe   = 10'((V_SCREEN - BALL_SIZE) / 2);
  localparam logic [9:0] YBottom  = 10'(V_SCREEN - BORDER - BALL_SIZE);
  localparam logic [9:0] YTop     = 10'(BORDER);
  localparam logic [2:0] StepBase = 3'(SPEED);

  state_e     state_q, state_d;
  logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic       dx_q, dx_d, dy_q, dy_d;
  logic       hit_q, hit_d, p1_q, p1_d, p2_q, p2_d, in_play_q;
  logic [2:0] step;
  logic       hit_r, hit_l, miss_r, miss_l, bounce_bot, bounce_top;

  ball_collide #(
    .H_SCREEN  (H_SCREEN),
    .V_SCREEN  (V_SCREEN),
    .BORDER    (BORDER),
    .BALL_SIZE (BALL_SIZE),
    .P_OFFSET  (P_OFFSET),
    .P_WIDTH   (P_WIDTH),
    .P_HIGH    (P_HIGH),
    .SPEED     (SPEED)
  ) u_collide (
    .ball_x     (ball_x_q),
    .ball_y     (ball_y_q),
    .dx_right   (dx_q),
    .dy_down    (dy_q),
    .step       (step),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .hit_r      (hit_r),
    .hit_l      (hit_l),
    .miss_r     (miss_r),
    .miss_l     (miss_l),
    .bounce_bot (bounce_bot),
    .bounce_top (bounce_top)
  );

  always_comb begin
    state_d  = state_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    hit_d    = 1'b0;
    p1_d     = 1'b0;
    p2_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        ball_x_d = serve_side ? XRight : XLeft;
        ball_y_d = YServe;
        dx_d     = 1'b1;
        dy_d     = 1'b1;
        if (serve) begin
          state_d = StPlay;
          dx_d    = !serve_side;
        end
      end
      StPlay: begin
        if (frame_tick) begin
          if (bounce_bot) begin
            ball_y_d = YBottom;
            dy_d     = 1'b0;
          end else if (bounce_top) begin
            ball_y_d = YTop;
            dy_d     = 1'b1;
          end else begin
            ball_y_d = dy_q ? ball_y_q + 10'(SPEED) : ball_y_q - 10'(SPEED);
          end
          // Paddle hit beats miss beats free motion.
          if (hit_r) begin
            ball_x_d = XRight;
            dx_d     = 1'b0;
            hit_d    = 1'b1;
          end else if (hit_l) begin
            ball_x_d = XLeft;
            dx_d     = 1'b1;
            hit_d    = 1'b1;
          end else if (miss_r) begin
            state_d  = StScored;
            ball_x_d = ball_x_q;
            p1_d     = 1'b1;
          end else if (miss_l) begin
            state_d  = StScored;
            ball_x_d = ball_x_q;
            p2_d     = 1'b1;
          end else begin
            ball_x_d = dx_q ? ball_x_q + 10'(step) : ball_x_q - 10'(step);
          end
        end
      end
      StScored: begin
        if (frame_tick) begin
          state_d  = StIdle;
          ball_x_d = serve_side ? XRight : XLeft;
          ball_y_d = YServe;
          dx_d     = 1'b1;
          dy_d     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state_q   <= StIdle;
      ball_x_q  <= XLeft;
      ball_y_q  <= YServe;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      hit_q     <= 1'b0;
      p1_q      <= 1'b0;
      p2_q      <= 1'b0;
      in_play_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      hit_q     <= hit_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      in_play_q <= (state_d == StPlay);
    end
  end

`ifdef BALL_ENGINE_SPEEDUP_EN
  localparam logic [2:0] StepMax = 3'(MaxStep);
  logic [1:0] hit_cnt_q, hit_cnt_d;
  logic [2:0] step_q, step_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    step_d    = step_q;
    if (state_q == StIdle) begin
      hit_cnt_d = 2'd0;
      step_d    = StepBase;
    end else if (hit_d) begin
      hit_cnt_d = hit_cnt_q + 2'd1;
      if (hit_cnt_q == 2'd3 && step_q < StepMax) step_d = step_q + 3'd1;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      hit_cnt_q <= 2'd0;
      step_q    <= StepBase;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      step_q    <= step_d;
    end
  end

  assign step = step_q;
`else
  assign step = StepBase;
`endif

  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign in_play    = in_play_q;
  assign paddle_hit = hit_q;
  assign point_p1   = p1_q;
  assign point_p2   = p2_q;

endmodule
